// File: rtl/note_decoder.sv
// note_decoder -- recognises which organ note is present on a square-wave tone input.
//
// The tone is synchronised and its rising edges are found. The time between consecutive
// rising edges is measured in microseconds and compared against a table of the 14 organ
// note periods. Two consecutive matching periods on the same note lock that note onto the
// registered outputs. If no edge arrives for longer than TIMEOUT, the input is treated as
// silence and the outputs are cleared.
//
// Parameters:
//   CLK_PER_US  clk_in cycles per 1 us measurement tick
//   TOL         match window in us, applied as +/- TOL around each table period
//   TIMEOUT     period count in us above which the input is treated as silence
//
// Ports:
//   clk_in   system clock; all logic runs on its rising edge
//   rst      synchronous, active-low reset
//   tone_in  asynchronous square-wave tone
//   note     decoded note: 0 = none, 1-7 = low do..si, 8-14 = middle do..si
//   valid    high while a note is locked
//   codeout  7-segment pattern {dp,g,f,e,d,c,b,a}, active-high; dp marks the middle octave
//   low      one-hot, bit i set when note = i+1
//   middle   one-hot, bit i set when note = i+8
module note_decoder #(
    parameter int unsigned CLK_PER_US = 50,
    parameter int unsigned TOL        = 20,
    parameter int unsigned TIMEOUT    = 4095
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tone_in,
    output logic [3:0] note,
    output logic       valid,
    output logic [7:0] codeout,
    output logic [6:0] low,
    output logic [6:0] middle
);

    localparam int unsigned    PreW    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(CLK_PER_US - 1);

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StConfirm,
        StLocked
    } state_e;

    // Nominal note period in us, indexed by note number 1..14.
    function automatic logic [11:0] period_us(input logic [3:0] k);
        logic [11:0] p;
        case (k)
            4'd1:    p = 12'd3822;
            4'd2:    p = 12'd3405;
            4'd3:    p = 12'd3034;
            4'd4:    p = 12'd2863;
            4'd5:    p = 12'd2551;
            4'd6:    p = 12'd2273;
            4'd7:    p = 12'd2025;
            4'd8:    p = 12'd1911;
            4'd9:    p = 12'd1703;
            4'd10:   p = 12'd1517;
            4'd11:   p = 12'd1431;
            4'd12:   p = 12'd1276;
            4'd13:   p = 12'd1136;
            4'd14:   p = 12'd1012;
            default: p = 12'd0;
        endcase
        return p;
    endfunction

    // True when the measured period lies within +/- TOL of the table period.
    function automatic logic in_window(input logic [11:0] meas, input logic [11:0] tab);
        int m;
        int t;
        m = int'(meas);
        t = int'(tab);
        return (m + int'(TOL) >= t) && (m <= t + int'(TOL));
    endfunction

    // Segment pattern {g,f,e,d,c,b,a} for digits 1..7; anything else is blank.
    function automatic logic [6:0] seg7(input logic [2:0] d);
        logic [6:0] s;
        case (d)
            3'd1:    s = 7'h06;
            3'd2:    s = 7'h5B;
            3'd3:    s = 7'h4F;
            3'd4:    s = 7'h66;
            3'd5:    s = 7'h6D;
            3'd6:    s = 7'h7D;
            3'd7:    s = 7'h07;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Input synchroniser and rising-edge detect
    // ------------------------------------------------------------------
    // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the delayed copy for edge detect.
    logic [2:0] sync_q;
    logic       tone_edge;

    assign tone_edge = sync_q[1] & ~sync_q[2];

    // ------------------------------------------------------------------
    // Microsecond prescaler and period counter
    // ------------------------------------------------------------------
    logic [PreW-1:0] pre_q, pre_d;
    logic [11:0]     cnt_q, cnt_d;
    logic            tick;
    logic            timeout;
    state_e          state_q;

    assign tick = (pre_q == PreLast);

    // The 12-bit counter saturates at 4095, so "exceeding TIMEOUT" is detected as the tick
    // that would carry the count past TIMEOUT.
    assign timeout = tick && (32'(cnt_q) >= TIMEOUT);

    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (state_q == StIdle || tone_edge) begin
            // Held at zero while idle; restarted on every edge so the next period starts clean.
            pre_d = '0;
            cnt_d = '0;
        end else if (tick) begin
            pre_d = '0;
            if (cnt_q != 12'hFFF) begin
                cnt_d = cnt_q + 12'd1;
            end
        end else begin
            pre_d = pre_q + PreW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            sync_q <= '0;
            pre_q  <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], tone_in};
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Period classification
    // ------------------------------------------------------------------
    logic [3:0] cand;

    always_comb begin
        cand = 4'd0;
        // Descending scan so that, with a wide TOL, the lowest matching note wins.
        for (int k = 14; k >= 1; k--) begin
            if (in_window(cnt_q, period_us(4'(k)))) begin
                cand = 4'(k);
            end
        end
    end

    // Output values that would be registered if cand were locked now.
    logic [2:0] digit;
    logic [7:0] lock_code;
    logic [6:0] lock_low;
    logic [6:0] lock_mid;

    always_comb begin
        digit     = (cand > 4'd7) ? 3'(cand - 4'd7) : cand[2:0];
        lock_code = {(cand > 4'd7), seg7(digit)};
        lock_low  = '0;
        lock_mid  = '0;
        for (int i = 0; i < 7; i++) begin
            if (cand == 4'(i + 1)) lock_low[i] = 1'b1;
            if (cand == 4'(i + 8)) lock_mid[i] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM with registered outputs
    // ------------------------------------------------------------------
    logic [3:0] stored_q;
    logic [3:0] note_q;
    logic       valid_q;
    logic [7:0] code_q;
    logic [6:0] low_q;
    logic [6:0] mid_q;

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q  <= StIdle;
            stored_q <= '0;
            note_q   <= '0;
            valid_q  <= 1'b0;
            code_q   <= '0;
            low_q    <= '0;
            mid_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // The first edge only starts a period; nothing can be measured yet.
                    if (tone_edge) begin
                        state_q <= StMeasure;
                    end
                end
                StMeasure: begin
                    if (timeout) begin
                        state_q <= StIdle;
                    end else if (tone_edge && cand != 4'd0) begin
                        stored_q <= cand;
                        state_q  <= StConfirm;
                    end
                end
                StConfirm: begin
                    if (timeout) begin
                        state_q <= StIdle;
                    end else if (tone_edge) begin
                        if (cand == 4'd0) begin
                            state_q <= StMeasure;
                        end else if (cand == stored_q) begin
                            state_q <= StLocked;
                            note_q  <= cand;
                            valid_q <= 1'b1;
                            code_q  <= lock_code;
                            low_q   <= lock_low;
                            mid_q   <= lock_mid;
                        end else begin
                            stored_q <= cand;
                        end
                    end
                end
                StLocked: begin
                    if (timeout) begin
                        state_q <= StIdle;
                        note_q  <= '0;
                        valid_q <= 1'b0;
                        code_q  <= '0;
                        low_q   <= '0;
                        mid_q   <= '0;
                    end else if (tone_edge && cand != stored_q) begin
                        note_q  <= '0;
                        valid_q <= 1'b0;
                        code_q  <= '0;
                        low_q   <= '0;
                        mid_q   <= '0;
                        if (cand == 4'd0) begin
                            state_q <= StMeasure;
                        end else begin
                            stored_q <= cand;
                            state_q  <= StConfirm;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign note    = note_q;
    assign valid   = valid_q;
    assign codeout = code_q;
    assign low     = low_q;
    assign middle  = mid_q;

endmodule

// File: tb/tb_note_decoder.sv
// tb_note_decoder -- directed self-checking bench for note_decoder.
//
// The main instance runs with CLK_PER_US = 1 so that one clock is one microsecond; a second
// instance with CLK_PER_US = 3 shares the same tone input and exercises the prescaler.
// With one clock per us, rising edges spaced N clocks apart measure a period of N-1 us.
module tb_note_decoder;

    logic       clk;
    logic       rst;
    logic       tone_in;

    logic [3:0] note;
    logic       valid;
    logic [7:0] codeout;
    logic [6:0] low;
    logic [6:0] middle;

    logic [3:0] note3;
    logic       valid3;
    logic [7:0] codeout3;
    logic [6:0] low3;
    logic [6:0] middle3;

    int vectors;
    int miscompares;

    // Window boundary cases: spacing in clocks and the note expected to lock.
    int         win_n    [6] = '{1931, 1932, 1933, 1961, 1892, 1891};
    logic [3:0] win_note [6] = '{4'd8, 4'd8, 4'd0, 4'd0, 4'd8, 4'd0};

    note_decoder #(
        .CLK_PER_US(1),
        .TOL       (20),
        .TIMEOUT   (4095)
    ) dut (
        .clk_in (clk),
        .rst    (rst),
        .tone_in(tone_in),
        .note   (note),
        .valid  (valid),
        .codeout(codeout),
        .low    (low),
        .middle (middle)
    );

    note_decoder #(
        .CLK_PER_US(3),
        .TOL       (20),
        .TIMEOUT   (4095)
    ) dut3 (
        .clk_in (clk),
        .rst    (rst),
        .tone_in(tone_in),
        .note   (note3),
        .valid  (valid3),
        .codeout(codeout3),
        .low    (low3),
        .middle (middle3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic apply_reset();
        tone_in = 1'b0;
        rst     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // One full tone period of n clocks, starting with its rising edge.
    task automatic tone_cycle(input int n);
        tone_in = 1'b1;
        repeat (n / 2) @(negedge clk);
        tone_in = 1'b0;
        repeat (n - n / 2) @(negedge clk);
    endtask

    // Rising edge followed by enough clocks for the lock to reach the outputs.
    task automatic rise_settle();
        tone_in = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (note !== 4'd0) begin
            miscompares++; $display("FAIL reset_note: got %0d want 0", note);
        end
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid: got %b want 0", valid);
        end
        vectors++;
        if (codeout !== 8'h00) begin
            miscompares++; $display("FAIL reset_codeout: got %h want 00", codeout);
        end
        vectors++;
        if ({low, middle} !== 14'd0) begin
            miscompares++; $display("FAIL reset_onehot: got %b/%b want 0/0", low, middle);
        end
        vectors++;
        if (valid3 !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid3: got %b want 0", valid3);
        end
    endtask

    // 1911 us periods: lock on the third edge with exact one-cycle output latency.
    task automatic test_lock_1911();
        apply_reset();
        tone_cycle(1912);
        tone_cycle(1912);
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++; $display("FAIL l1911_two_edges_valid: got %b want 0", valid);
        end
        tone_in = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++; $display("FAIL l1911_early_valid: got %b want 0", valid);
        end
        @(negedge clk);
        vectors++;
        if (valid !== 1'b1) begin
            miscompares++; $display("FAIL l1911_valid: got %b want 1", valid);
        end
        vectors++;
        if (note !== 4'd8) begin
            miscompares++; $display("FAIL l1911_note: got %0d want 8", note);
        end
        vectors++;
        if (codeout !== 8'h86) begin
            miscompares++; $display("FAIL l1911_codeout: got %h want 86", codeout);
        end
        vectors++;
        if (middle !== 7'b0000001 || low !== 7'b0) begin
            miscompares++; $display("FAIL l1911_onehot: got %b/%b want 0000000/0000001", low, middle);
        end
        repeat (1912 / 2 - 3) @(negedge clk);
        tone_in = 1'b0;
        repeat (1912 - 1912 / 2) @(negedge clk);
        tone_cycle(1912);
        vectors++;
        if (valid !== 1'b1 || note !== 4'd8 || codeout !== 8'h86) begin
            miscompares++;
            $display("FAIL l1911_held: got v=%b n=%0d c=%h want v=1 n=8 c=86", valid, note, codeout);
        end
    endtask

    // 3822 us then 3405 us: drop on the first new period, relock on the next edge.
    task automatic test_switch();
        apply_reset();
        repeat (3) tone_cycle(3823);
        vectors++;
        if (valid !== 1'b1 || note !== 4'd1 || codeout !== 8'h06 || low !== 7'b0000001) begin
            miscompares++;
            $display("FAIL sw_lock1: got v=%b n=%0d c=%h l=%b want v=1 n=1 c=06 l=0000001",
                     valid, note, codeout, low);
        end
        tone_cycle(3406);
        vectors++;
        if (valid !== 1'b1 || note !== 4'd1) begin
            miscompares++; $display("FAIL sw_hold: got v=%b n=%0d want v=1 n=1", valid, note);
        end
        tone_cycle(3406);
        vectors++;
        if (valid !== 1'b0 || note !== 4'd0 || codeout !== 8'h00 || low !== 7'b0) begin
            miscompares++;
            $display("FAIL sw_drop: got v=%b n=%0d c=%h l=%b want all 0", valid, note, codeout, low);
        end
        rise_settle();
        vectors++;
        if (valid !== 1'b1 || note !== 4'd2 || codeout !== 8'h5B || low !== 7'b0000010) begin
            miscompares++;
            $display("FAIL sw_lock2: got v=%b n=%0d c=%h l=%b want v=1 n=2 c=5b l=0000010",
                     valid, note, codeout, low);
        end
        tone_in = 1'b0;
    endtask

    // Periods at and just beyond the +/- 20 us window around 1911, plus 1930 and 1960.
    task automatic test_window();
        for (int i = 0; i < 6; i++) begin
            apply_reset();
            tone_cycle(win_n[i]);
            tone_cycle(win_n[i]);
            rise_settle();
            vectors++;
            if (note !== win_note[i] || valid !== (win_note[i] != 4'd0)) begin
                miscompares++;
                $display("FAIL window_p%0d: got v=%b n=%0d want v=%b n=%0d", win_n[i] - 1,
                         valid, note, (win_note[i] != 4'd0), win_note[i]);
            end
            tone_in = 1'b0;
        end
    endtask

    // Tone stops while locked to note 5: outputs clear once the count passes 4095 us.
    task automatic test_timeout();
        apply_reset();
        tone_cycle(2552);
        tone_cycle(2552);
        tone_in = 1'b1;
        repeat (3) @(negedge clk);
        tone_in = 1'b0;
        vectors++;
        if (valid !== 1'b1 || note !== 4'd5 || codeout !== 8'h6D || low !== 7'b0010000) begin
            miscompares++;
            $display("FAIL to_lock: got v=%b n=%0d c=%h l=%b want v=1 n=5 c=6d l=0010000",
                     valid, note, codeout, low);
        end
        repeat (4080) @(negedge clk);
        vectors++;
        if (valid !== 1'b1 || note !== 4'd5) begin
            miscompares++; $display("FAIL to_before: got v=%b n=%0d want v=1 n=5", valid, note);
        end
        repeat (30) @(negedge clk);
        vectors++;
        if (valid !== 1'b0 || note !== 4'd0 || codeout !== 8'h00 || low !== 7'b0) begin
            miscompares++;
            $display("FAIL to_after: got v=%b n=%0d c=%h l=%b want all 0", valid, note, codeout, low);
        end
    endtask

    // One-cycle reset while locked to note 14, then three fresh edges needed.
    task automatic test_reset_locked();
        apply_reset();
        tone_cycle(1013);
        tone_cycle(1013);
        rise_settle();
        vectors++;
        if (valid !== 1'b1 || note !== 4'd14 || codeout !== 8'h87 || middle !== 7'b1000000) begin
            miscompares++;
            $display("FAIL rl_lock: got v=%b n=%0d c=%h m=%b want v=1 n=14 c=87 m=1000000",
                     valid, note, codeout, middle);
        end
        tone_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        vectors++;
        if (valid !== 1'b0 || note !== 4'd0 || codeout !== 8'h00 || middle !== 7'b0) begin
            miscompares++;
            $display("FAIL rl_cleared: got v=%b n=%0d c=%h m=%b want all 0",
                     valid, note, codeout, middle);
        end
        tone_cycle(1013);
        tone_cycle(1013);
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++; $display("FAIL rl_two_edges: got v=%b want 0", valid);
        end
        rise_settle();
        vectors++;
        if (valid !== 1'b1 || note !== 4'd14) begin
            miscompares++; $display("FAIL rl_relock: got v=%b n=%0d want v=1 n=14", valid, note);
        end
        tone_in = 1'b0;
    endtask

    // Single-cycle glitches every 10 us never match a note.
    task automatic test_glitch();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            tone_in = 1'b1;
            @(negedge clk);
            tone_in = 1'b0;
            repeat (9) @(negedge clk);
        end
        vectors++;
        if (valid !== 1'b0 || note !== 4'd0 || codeout !== 8'h00) begin
            miscompares++;
            $display("FAIL glitch: got v=%b n=%0d c=%h want all 0", valid, note, codeout);
        end
    endtask

    // 3037-clock spacing: 1012 us at 3 clocks/us (note 14), 3036 us at 1 clock/us (note 3).
    task automatic test_prescale();
        apply_reset();
        tone_cycle(3037);
        tone_cycle(3037);
        rise_settle();
        vectors++;
        if (valid3 !== 1'b1 || note3 !== 4'd14 || codeout3 !== 8'h87 || middle3 !== 7'b1000000) begin
            miscompares++;
            $display("FAIL pre_div3: got v=%b n=%0d c=%h m=%b want v=1 n=14 c=87 m=1000000",
                     valid3, note3, codeout3, middle3);
        end
        vectors++;
        if (valid !== 1'b1 || note !== 4'd3 || codeout !== 8'h4F || low !== 7'b0000100) begin
            miscompares++;
            $display("FAIL pre_div1: got v=%b n=%0d c=%h l=%b want v=1 n=3 c=4f l=0000100",
                     valid, note, codeout, low);
        end
        tone_in = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        tone_in     = 1'b0;
        @(negedge clk);
        test_reset();
        test_lock_1911();
        test_switch();
        test_window();
        test_timeout();
        test_reset_locked();
        test_glitch();
        test_prescale();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/note_decoder.md
NOTE_DECODER -- requirements
Module: note_decoder

Interface
REQ-001 Parameter CLK_PER_US, default 50, SHALL set clk_in cycles per 1 us measurement tick.
REQ-002 Parameter TOL, default 20, SHALL set the match window in us, +/- around each table period.
REQ-003 Parameter TIMEOUT, default 4095, SHALL set the period count in us above which input is treated as silence.
REQ-004 clk_in  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 tone_in  input  1  asynchronous square-wave tone, as produced by the organ's clk_out2.
REQ-007 note  output  4  decoded note: 0 = none, 1-7 = low do-si, 8-14 = middle do-si.
REQ-008 valid  output  1  high while a note is locked.
REQ-009 codeout  output  8  7-seg pattern {dp,g,f,e,d,c,b,a}, active-high.
REQ-010 low  output  7  one-hot, bit i high when note = i+1.
REQ-011 middle  output  7  one-hot, bit i high when note = i+8.

Function
REQ-012 tone_in SHALL pass a 2-flop synchronizer; a rising edge is detected on the synchronized signal (3 cycles of latency from pin to edge pulse).
REQ-013 A prescaler SHALL emit a 1-cycle tick every CLK_PER_US cycles; the period counter is 12 bits, increments on tick, and saturates at 4095.
REQ-014 The period table in us SHALL be: 1:3822 2:3405 3:3034 4:2863 5:2551 6:2273 7:2025 8:1911 9:1703 10:1517 11:1431 12:1276 13:1136 14:1012.
REQ-015 A measured period P SHALL match entry k when |P - table[k]| <= TOL; with the default TOL at most one entry can match, and no match gives candidate 0.
REQ-016 The FSM SHALL have states IDLE, MEASURE, CONFIRM, LOCKED.
REQ-017 IDLE: the counter and prescaler are held at 0; the first edge SHALL go to MEASURE.
REQ-018 On each edge in MEASURE, CONFIRM or LOCKED, the counter value SHALL be the period P; the counter and prescaler clear in that same cycle.
REQ-019 MEASURE on edge: candidate != 0 SHALL store the candidate and go to CONFIRM; candidate 0 SHALL stay in MEASURE.
REQ-020 CONFIRM on edge: a candidate equal to the stored one SHALL go to LOCKED; any other non-zero candidate replaces the stored one and stays; 0 SHALL return to MEASURE.
REQ-021 LOCKED on edge: the same candidate SHALL stay; a different non-zero candidate goes to CONFIRM and stores it; 0 goes to MEASURE. Every exit from LOCKED clears the outputs.
REQ-022 From MEASURE, CONFIRM or LOCKED, a counter exceeding TIMEOUT SHALL go to IDLE and clear the outputs.
REQ-023 If an edge and the timeout occur in the same cycle, the timeout SHALL take priority.
REQ-024 Outputs SHALL be registered and update on the cycle after the edge that enters LOCKED.
REQ-025 Outputs SHALL be held constant while in LOCKED.
REQ-026 Digit d = note for notes 1-7 and note-7 for notes 8-14; segments SHALL be 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 (hex).
REQ-027 dp (codeout[7]) SHALL be set for the middle octave.
REQ-028 When note = 0, codeout, low and middle SHALL be 0.

Reset
REQ-029 With rst = 0 at a clock edge, the block SHALL enter IDLE and clear the synchronizer, prescaler and counter.
REQ-030 The same reset SHALL set note = 0, valid = 0, codeout = 8'h00, low = 0, middle = 0.
REQ-031 Reset mid-measurement SHALL discard any partial period.
REQ-032 Outputs SHALL stay cleared until a new lock, which needs 3 rising edges after reset release.

Verification
REQ-033 Scenario: 4 periods of 1911 us -> after the 3rd edge, note = 8, valid = 1, codeout = 8'h86, middle = 7'b0000001, low = 0.
REQ-034 Scenario: 3822 us periods, then switch to 3405 us -> first locks to note 1, codeout 8'h06; after the switch, valid drops on the first 3405 us edge and relocks to note 2, codeout 8'h5B, on the next edge.
REQ-035 Scenario: periods of 1930 us (inside the 1911 +/- 20 window) -> locks to note 8; periods of 1960 us -> never locks, valid = 0.
REQ-036 Scenario: tone_in stops while locked to note 5 -> valid = 0, note = 0 and the FSM returns to IDLE once the counter passes 4095 us.
REQ-037 Scenario: rst pulled low for 1 cycle while in LOCKED -> all outputs are 0 on the next cycle, and the next lock occurs only after 3 fresh edges.
REQ-038 Scenario: single-cycle glitch pulses at 10 us spacing -> never matches and valid stays 0.
